sort10_batcher: RTL
===================

Name: sort10_batcher

Overview:
- Upstream collector for the 10-into-100 sorted merge stage.
- Accepts samples serially over a valid/ready handshake and keeps them in a 10-entry register array, sorted ascending by insertion.
- Presents the completed batch in parallel with per-element arrival tags, in the `a[9:0]` / `a_id` form the merge stage consumes.
- Supports early batch termination, padding empty slots with a maximal value.

Parameters:
WIDTH, 16, data width of each sample (unsigned compare)
PAD_VAL, {WIDTH{1'b1}}, value placed in unfilled slots of a short batch

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  sample offered
in_ready  output  1  block can accept a sample this cycle
in_data  input  WIDTH  sample value
in_last  input  1  with accepted sample: final sample of this batch
out_valid  output  1  sorted batch available
out_ready  input  1  consumer takes batch
out_data  output  WIDTH x [9:0]  sorted batch; [0] smallest, [9] largest
out_id  output  4 x [9:0]  arrival index (0..9) of each out_data entry; 4'hF for pad slots
out_count  output  4  number of real samples in batch, 1..10

Behaviour:
- Accept means `in_valid && in_ready` at a rising edge.
- Deliver means `out_valid && out_ready` at a rising edge.
- States:
  - FILL: `in_ready=1`, `out_valid=0`.
  - FULL: `in_ready=0`, `out_valid=1`.
  - `in_ready`, `out_valid`, `out_data`, `out_id`, `out_count` come directly from registers or state decode; no combinational path from inputs.
- Reset (rst=1 at an edge), regardless of state or handshakes:
  - state=FILL, fill count n=0;
  - all data entries = PAD_VAL; all ids = 4'hF; `out_count`=0.
  - Any partial batch is discarded.
  - After reset: `in_ready`=1, `out_valid`=0.
- Insertion on accept in FILL, with n entries already held:
  - p = number of held entries with value <= in_data (stable: equal values keep arrival order).
  - Entries p..n-1 shift up one slot; slot p gets in_data with id=n; n increments.
  - Exactly one sample is inserted per cycle; single-cycle insertion, no stall.
- Transition FILL -> FULL on an accept when the new n == 10 or in_last=1.
  - `out_valid` rises the cycle after that accept (latency 1 from the last sample).
  - `out_count` = n after insertion.
  - Slots n..9 hold PAD_VAL with id 4'hF. Real samples equal to PAD_VAL sort before pad slots (stable rule).
- FULL:
  - `out_data`/`out_id`/`out_count` held stable while `out_ready`=0.
  - `in_valid` is ignored; no sample is lost because `in_ready`=0.
- Transition FULL -> FILL on deliver: n=0, entries=PAD_VAL, ids=4'hF, `out_count`=0.
  - `in_ready`=1 from the next cycle.
  - No accept occurs in the delivering cycle.
  - Throughput: a 10-sample batch needs 11 cycles minimum (10 accepts + 1 deliver).
- `in_last` without `in_valid` is ignored.
- A batch always contains at least 1 sample.
- Comparison is unsigned, full WIDTH.

Test Plan:
- Reset then feed 10 samples 9,3,7,1,8,2,6,0,5,4 back-to-back with `out_ready`=0 -> `in_ready` drops after the 10th; `out_valid`=1 the next cycle; `out_data`=0..9 ascending; `out_id`=[7,3,5,1,9,8,6,2,4,0]; `out_count`=10; outputs stable until `out_ready`.
- Duplicates: feed 5,5,2,5,2,9,9,0,5,1 -> `out_data`=0,1,2,2,5,5,5,5,9,9; `out_id` for the 2s = [2,4], the 5s = [0,1,3,8], the 9s = [5,6] (stable order).
- Short batch: feed 40,10,30 with `in_last` on 30 -> `out_count`=3; `out_data`=[10,30,40,PAD_VAL x7]; `out_id`=[1,2,0,F x7]; then a single sample 7 with `in_last` -> `out_count`=1, `out_data[0]`=7.
- Backpressure/overlap: hold `in_valid`=1 continuously and toggle `out_ready` -> no sample accepted while `out_valid`=1; deliver cycle clears the batch; the next batch's first sample is accepted the cycle after deliver, with id 0.
- Reset mid-operation: rst after 4 accepts, and rst while FULL with `out_ready`=1 -> next cycle `out_valid`=0, `in_ready`=1, `out_count`=0, all `out_data`=PAD_VAL; the following batch is unaffected by prior contents.
- Extremes: WIDTH=16 samples 0xFFFF,0x0000,0xFFFF with `in_last` -> `out_data`=[0x0000,0xFFFF,0xFFFF,pad...]; `out_id`=[1,0,2,F...]; `out_count`=3.

Source files
------------

// File: rtl/sort10_batcher_if.sv
// Handshake bundle between a sample producer, the sort10_batcher and the merge stage.
// slave is the batcher side, master the producer/consumer side.
interface sort10_batcher_if #(
  parameter int WIDTH = 16
);
  logic                   in_valid;
  logic                   in_ready;
  logic [WIDTH-1:0]       in_data;
  logic                   in_last;
  logic                   out_valid;
  logic                   out_ready;
  logic [9:0][WIDTH-1:0]  out_data;
  logic [9:0][3:0]        out_id;
  logic [3:0]             out_count;
  logic [0:0]             state;

  // valid/ready: a transfer happens on a rising edge where both are high; the
  // sender holds its payload stable while valid is high and ready is low, and
  // neither ready nor valid out of the batcher depends combinationally on inputs.
  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_id, out_count, state
  );

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_id, out_count, state
  );
endinterface

// File: rtl/sort10_batcher.sv
// Collects up to ten samples by stable insertion into a sorted register array and
// presents the batch in parallel with arrival ids; short batches are padded.
module sort10_batcher #(
  parameter int               WIDTH   = 16,
  parameter logic [WIDTH-1:0] PAD_VAL = {WIDTH{1'b1}}
) (
  input logic             clk,
  input logic             rst,
  sort10_batcher_if.slave bus
);
  localparam logic [0:0] ST_FILL = 1'b0;
  localparam logic [0:0] ST_FULL = 1'b1;
  localparam logic [3:0] PAD_ID  = 4'hF;

  logic [0:0]            state;
  logic [3:0]            n;
  logic [3:0]            count;
  logic [9:0][WIDTH-1:0] data_q;
  logic [9:0][3:0]       id_q;

  logic [9:0]            le;
  logic [9:0]            le_prev;
  logic [9:0][WIDTH-1:0] data_up;
  logic [9:0][3:0]       id_up;
  logic [9:0][WIDTH-1:0] data_nxt;
  logic [9:0][3:0]       id_nxt;
  logic                  accept;
  logic [3:0]            n_inc;
  logic                  go_full;

  assign accept  = bus.in_valid && (state == ST_FILL);
  assign n_inc   = n + 4'd1;
  assign go_full = accept && ((n_inc == 4'd10) || bus.in_last);

  // Held entries are sorted, so le is a prefix mask; the insert slot is the
  // first clear bit. Gating with the fill count keeps real samples equal to
  // PAD_VAL ahead of the pad slots.
  always_comb begin
    le = '0;
    for (int i = 0; i < 10; i++) begin
      le[i] = (i < int'(n)) && (data_q[i] <= bus.in_data);
    end
  end

  assign le_prev = {le[8:0], 1'b1};
  assign data_up = {data_q[8:0], PAD_VAL};
  assign id_up   = {id_q[8:0], PAD_ID};

  always_comb begin
    data_nxt = data_q;
    id_nxt   = id_q;
    for (int i = 0; i < 10; i++) begin
      if (le[i]) begin
        data_nxt[i] = data_q[i];
        id_nxt[i]   = id_q[i];
      end else if (le_prev[i]) begin
        data_nxt[i] = bus.in_data;
        id_nxt[i]   = n;
      end else if (i <= int'(n)) begin
        data_nxt[i] = data_up[i];
        id_nxt[i]   = id_up[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_FILL;
      n      <= 4'd0;
      count  <= 4'd0;
      data_q <= {10{PAD_VAL}};
      id_q   <= {10{PAD_ID}};
    end else begin
      case (state)
        ST_FILL: begin
          if (accept) begin
            data_q <= data_nxt;
            id_q   <= id_nxt;
            n      <= n_inc;
            if (go_full) begin
              state <= ST_FULL;
              count <= n_inc;
            end
          end
        end
        ST_FULL: begin
          if (bus.out_ready) begin
            state  <= ST_FILL;
            n      <= 4'd0;
            count  <= 4'd0;
            data_q <= {10{PAD_VAL}};
            id_q   <= {10{PAD_ID}};
          end
        end
        default: state <= ST_FILL;
      endcase
    end
  end

  assign bus.in_ready  = (state == ST_FILL);
  assign bus.out_valid = (state == ST_FULL);
  assign bus.out_data  = data_q;
  assign bus.out_id    = id_q;
  assign bus.out_count = count;
  assign bus.state     = state;
endmodule
